pam4_symbol_source: RTL and testbench

//  Stimulus stage directly upstream of the ISI channel model. Generates a PRBS bit

---
 rtl/pam4_symbol_source.sv | 144 ++++++++++++++
 tb/tb_pam4_symbol_source.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam4_symbol_source.sv
// PAM-4 symbol source: PRBS bits, optional Gray map, signed levels.
// Emits a strobed symbol stream with programmable spacing and burst length.
module pam4_symbol_source #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int PRBS_ORDER = 7,
  parameter logic [PRBS_ORDER-1:0] PRBS_SEED = '1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic                                stop,
  input  logic [31:0]                         num_symbols,
  input  logic [7:0]                          interval,
  input  logic                                gray_en,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid,
  output logic [1:0]                          symbol_idx,
  output logic                                busy,
  output logic                                done
);

  localparam int W = SIGNAL_RESOLUTION;
  localparam int S = SYMBOL_SEPERATION;
  localparam int N = PRBS_ORDER;
  localparam int TAP = (N == 7) ? 5 : (N == 15) ? 13 : 27;

  localparam logic signed [W-1:0] LV0 = W'(-(3 * S) / 2);
  localparam logic signed [W-1:0] LV1 = W'(-S / 2);
  localparam logic signed [W-1:0] LV2 = W'(S / 2);
  localparam logic signed [W-1:0] LV3 = W'((3 * S) / 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  lfsr_q;
  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [31:0]   cnt_q;
  logic [31:0]   num_q;
  logic [7:0]    icnt_q;
  logic [7:0]    intv_q;
  logic          gray_q;
  logic          emit;
  logic          load;
  logic [1:0]    idx_d;
  logic signed [W-1:0] lvl_d;

  function automatic logic [N-1:0] step(
    input logic [N-1:0] s
  );
    step = {s[N-2:0], s[N-1] ^ s[TAP]};
  endfunction

  // Two LFSR steps per symbol: first new bit is the MSB.
  always_comb begin
    s1 = step(lfsr_q);
    s2 = step(s1);
    idx_d = gray_q ? {s1[0], s1[0] ^ s2[0]}
                   : {s1[0], s2[0]};
  end

  always_comb begin
    lvl_d = LV0;
    unique case (idx_d)
      2'd0: lvl_d = LV0;
      2'd1: lvl_d = LV1;
      2'd2: lvl_d = LV2;
      2'd3: lvl_d = LV3;
      default: lvl_d = LV0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    emit = 1'b0;
    load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          load = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (icnt_q == 8'd0) begin
          emit = 1'b1;
          if (num_q != 32'd0 &&
              cnt_q + 32'd1 == num_q)
            state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      lfsr_q <= PRBS_SEED;
      cnt_q <= '0;
      icnt_q <= '0;
      num_q <= '0;
      intv_q <= '0;
      gray_q <= 1'b0;
      signal_out <= '0;
      symbol_idx <= '0;
      signal_out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      signal_out_valid <= emit;
      busy <= (state_d == RUN) || emit;
      done <= (state_q == DONE);
      if (load) begin
        lfsr_q <= PRBS_SEED;
        cnt_q <= '0;
        icnt_q <= '0;
        num_q <= num_symbols;
        intv_q <= interval;
        gray_q <= gray_en;
      end else if (state_q == RUN && !stop) begin
        icnt_q <= (icnt_q == intv_q) ? 8'd0
                                     : icnt_q + 8'd1;
      end
      if (emit) begin
        lfsr_q <= s2;
        cnt_q <= cnt_q + 32'd1;
        signal_out <= lvl_d;
        symbol_idx <= idx_d;
      end
    end
  end

endmodule

// File: tb/tb_pam4_symbol_source.sv
// Scoreboard bench for pam4_symbol_source against a PRBS7
// recurrence model with level/Gray tables.
module tb_pam4_symbol_source;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [31:0] num_symbols = '0;
  logic [7:0] interval = '0;
  logic gray_en = 1'b0;
  logic signed [7:0] signal_out;
  logic signal_out_valid;
  logic [1:0] symbol_idx;
  logic busy;
  logic done;

  pam4_symbol_source dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .stop(stop),
    .num_symbols(num_symbols),
    .interval(interval),
    .gray_en(gray_en),
    .signal_out(signal_out),
    .signal_out_valid(signal_out_valid),
    .symbol_idx(symbol_idx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int idx;
  } exp_t;

  exp_t sbq[$];
  int strobe_cyc[$];
  int got[$];
  int cyc = 0;
  int ndone = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn && done) ndone++;
    if (rstn && signal_out_valid) begin
      strobe_cyc.push_back(cyc);
      got.push_back(int'(signal_out));
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d lvl=%0d",
                 cyc, signal_out);
      end else begin
        e = sbq.pop_front();
        if (int'(signal_out) != e.lvl ||
            int'(symbol_idx) != e.idx) begin
          errors++;
          $display("FAIL symbol cyc=%0d got lvl=%0d idx=%0d want lvl=%0d idx=%0d",
                   cyc, signal_out, symbol_idx, e.lvl, e.idx);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  // PRBS7 as a bit recurrence: b[n] = b[n-7] ^ b[n-6].
  task automatic push_expected(input int n, input bit g);
    int hist[$];
    int b1;
    int b0;
    int id;
    int gmap[4] = '{0, 1, 3, 2};
    exp_t e;
    for (int i = 0; i < 7; i++) hist.push_back(1);
    for (int k = 0; k < n; k++) begin
      b1 = hist[0] ^ hist[1];
      hist.push_back(b1);
      void'(hist.pop_front());
      b0 = hist[0] ^ hist[1];
      hist.push_back(b0);
      void'(hist.pop_front());
      id = g ? gmap[b1 * 2 + b0] : b1 * 2 + b0;
      e.idx = id;
      e.lvl = -84 + 56 * id;
      sbq.push_back(e);
    end
  endtask

  task automatic run_burst(input int n, input int intv,
                           input bit g, input bit mid_start);
    int c0;
    int dc;
    int bad;
    int nd0;
    int maxc;
    bit bok;
    push_expected(n, g);
    strobe_cyc.delete();
    got.delete();
    nd0 = ndone;
    maxc = n * (intv + 1) + 10;
    num_symbols = n;
    interval = intv[7:0];
    gray_en = g;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
    bok = busy;
    dc = -1;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk);
      #2;
      start = (mid_start && k == 3);
      if (done) begin
        dc = cyc;
        break;
      end
      if (!busy) bok = 1'b0;
    end
    start = 1'b0;
    chk("strobe_count", strobe_cyc.size(), n);
    chk("first_latency",
        strobe_cyc.size() > 0 ? strobe_cyc[0] : -1, c0 + 2);
    bad = 0;
    for (int i = 1; i < strobe_cyc.size(); i++)
      if (strobe_cyc[i] - strobe_cyc[i-1] != intv + 1) bad++;
    chk("spacing_errors", bad, 0);
    chk("done_cycle", dc,
        strobe_cyc.size() > 0 ? strobe_cyc[$] + 1 : -2);
    chk("busy_throughout", bok, 1);
    chk("sbq_drained", sbq.size(), 0);
    @(posedge clk);
    #2;
    chk("done_one_cycle", done, 0);
    chk("done_pulses", ndone - nd0, 1);
  endtask

  initial begin
    int sc;
    int nd0;
    int bad;
    int n;
    int iv;
    bit g;
    bit ok;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_signal_out", signal_out, 0);
    chk("rst_valid", signal_out_valid, 0);
    chk("rst_idx", symbol_idx, 0);
    chk("rst_busy_done", {busy, done}, 0);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    run_burst(4, 0, 1'b0, 1'b0);
    chk("bin_s3", got.size() > 3 ? got[3] : 999, 28);
    chk("bin_s0", got.size() > 0 ? got[0] : 999, -84);
    run_burst(4, 0, 1'b1, 1'b0);
    chk("gray_s3", got.size() > 3 ? got[3] : 999, 84);
    run_burst(5, 3, 1'b0, 1'b0);
    run_burst(8, 2, 1'b1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20);
      iv = $urandom_range(0, 5);
      g = 1'($urandom_range(0, 1));
      run_burst(n, iv, g, 1'b0);
    end

    // Endless burst, then stop.
    push_expected(400, 1'b0);
    strobe_cyc.delete();
    got.delete();
    nd0 = ndone;
    num_symbols = 0;
    interval = 0;
    gray_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #2;
      if (strobe_cyc.size() >= 300) begin
        ok = 1'b1;
        break;
      end
    end
    chk("endless_reached_300", ok, 1);
    stop = 1'b1;
    sc = strobe_cyc.size();
    @(posedge clk);
    #2;
    stop = 1'b0;
    chk("stop_busy_low", busy, 0);
    repeat (10) @(posedge clk);
    #2;
    chk("stop_no_more_strobes", strobe_cyc.size(), sc + 1);
    chk("stop_no_done", ndone - nd0, 0);
    bad = 0;
    for (int k = 0; k + 127 < got.size(); k++)
      if (got[k] != got[k + 127]) bad++;
    chk("prbs_period_127", bad, 0);
    sbq.delete();

    // start with stop in IDLE.
    sc = strobe_cyc.size();
    num_symbols = 3;
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", busy, 0);
    repeat (5) @(posedge clk);
    #2;
    chk("startstop_no_strobe", strobe_cyc.size(), sc);

    // Reset in the middle of a burst.
    push_expected(20, 1'b0);
    nd0 = ndone;
    num_symbols = 20;
    interval = 1;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_signal_out", signal_out, 0);
    chk("midrst_valid_busy", {signal_out_valid, busy}, 0);
    chk("midrst_idx", symbol_idx, 0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    sbq.delete();
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_no_done", ndone - nd0, 0);
    run_burst(4, 0, 1'b0, 1'b0);
    chk("replay_s0", got.size() > 0 ? got[0] : 999, -84);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
